// File: rtl/loader_pkg.sv
// Shared types and helpers for the instruction-memory program loader.
// The CHECK state exists only when LOADER_CHECKSUM_EN is defined.
package loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LEN_LO = 3'd1,
        ST_LEN_HI = 3'd2,
        ST_DATA   = 3'd3,
        ST_FLUSH  = 3'd4,
`ifdef LOADER_CHECKSUM_EN
        ST_CHECK  = 3'd5,
`endif
        ST_DONE   = 3'd6,
        ST_ERR    = 3'd7
    } loader_state_t;

    localparam int LEN_BYTES      = 2;
    localparam int BYTES_PER_WORD = 4;

    function automatic logic accepts_byte(input loader_state_t s);
`ifdef LOADER_CHECKSUM_EN
        return (s == ST_LEN_LO) || (s == ST_LEN_HI) || (s == ST_DATA) || (s == ST_CHECK);
`else
        return (s == ST_LEN_LO) || (s == ST_LEN_HI) || (s == ST_DATA);
`endif
    endfunction

    function automatic logic is_busy(input loader_state_t s);
        return accepts_byte(s) || (s == ST_FLUSH);
    endfunction

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Packs accepted stream bytes into little-endian 32-bit words.
// word/word_complete are valid in the cycle the fourth byte is accepted.
module byte_packer
    import loader_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        accept,
    input  logic [7:0]  data,
    output logic [31:0] word,
    output logic        word_complete
);

    logic [1:0]  idx;
    logic [23:0] lower;

    assign word_complete = accept && (idx == 2'(BYTES_PER_WORD - 1));
    assign word          = {data, lower};

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            idx   <= '0;
            lower <= '0;
        end else if (accept) begin
            idx <= idx + 2'd1;
            case (idx)
                2'd0:    lower[7:0]   <= data;
                2'd1:    lower[15:8]  <= data;
                2'd2:    lower[23:16] <= data;
                default: lower        <= lower;
            endcase
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Length-prefixed byte stream to instruction memory loader; holds the core in reset until done.
// Optional trailing checksum byte verification is enabled with LOADER_CHECKSUM_EN.
module imem_loader
    import loader_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        cpu_reset,
    output logic        busy,
    output logic        done,
    output logic        error
);

    localparam logic [16:0] CAPACITY = 17'd1 << ADDR_W;

`ifdef LOADER_CHECKSUM_EN
    localparam loader_state_t ST_AFTER_DATA = ST_CHECK;
`else
    localparam loader_state_t ST_AFTER_DATA = ST_DONE;
`endif

    loader_state_t state, state_nx;
    logic [15:0] n_words;
    logic [15:0] word_idx;
    logic [16:0] n_full;
    logic        xfer;
    logic        start_ok;
    logic [31:0] packed_word;
    logic        word_complete;

    assign xfer     = in_valid && in_ready;
    assign start_ok = start && !is_busy(state);
    assign n_full   = {1'b0, in_data, n_words[7:0]};

    byte_packer u_packer (
        .clk           (clk),
        .reset         (reset),
        .clear         (start_ok),
        .accept        (xfer && (state == ST_DATA)),
        .data          (in_data),
        .word          (packed_word),
        .word_complete (word_complete)
    );

`ifdef LOADER_CHECKSUM_EN
    logic [7:0] csum, csum_nx;

    assign csum_nx = csum + in_data;

    always_ff @(posedge clk) begin
        if (reset || start_ok) begin
            csum <= '0;
        end else if (xfer) begin
            csum <= csum_nx;
        end
    end
`endif

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE, ST_DONE, ST_ERR: if (start) state_nx = ST_LEN_LO;
            ST_LEN_LO:                if (xfer) state_nx = ST_LEN_HI;
            ST_LEN_HI: begin
                if (xfer) begin
                    if (n_full > CAPACITY)  state_nx = ST_ERR;
                    else if (n_full == '0)  state_nx = ST_AFTER_DATA;
                    else                    state_nx = ST_DATA;
                end
            end
            ST_DATA:  if (word_complete && (word_idx == 16'(n_words - 16'd1))) state_nx = ST_FLUSH;
            ST_FLUSH: state_nx = ST_AFTER_DATA;
`ifdef LOADER_CHECKSUM_EN
            ST_CHECK: if (xfer) state_nx = (csum_nx == 8'd0) ? ST_DONE : ST_ERR;
`endif
            default:  state_nx = ST_IDLE;
        endcase
    end

    // Status outputs are registered from the next state so they line up with the state they describe.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            n_words   <= '0;
            word_idx  <= '0;
            in_ready  <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            cpu_reset <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
            error     <= 1'b0;
        end else begin
            state     <= state_nx;
            in_ready  <= accepts_byte(state_nx);
            busy      <= is_busy(state_nx);
            done      <= (state_nx == ST_DONE);
            error     <= (state_nx == ST_ERR);
            cpu_reset <= (state_nx != ST_DONE);
            mem_we    <= word_complete;
            if (xfer && (state == ST_LEN_LO)) n_words[7:0]  <= in_data;
            if (xfer && (state == ST_LEN_HI)) n_words[15:8] <= in_data;
            if (word_complete) begin
                mem_addr  <= {14'd0, word_idx, 2'b00};
                mem_wdata <= packed_word;
                word_idx  <= word_idx + 16'd1;
            end
            if (start_ok) word_idx <= '0;
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: directed image loads plus randomized images
// compared against a byte-stream model; also covers LOADER_CHECKSUM_EN builds.
module tb_imem_loader;

    localparam int ADDR_W = 2;
    localparam int CAP    = 1 << ADDR_W;

    typedef logic [7:0] bq_t[$];

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        cpu_reset;
    logic        busy;
    logic        done;
    logic        error;

    int          checks = 0;
    int          failures = 0;
    logic [63:0] wr_q[$];
    bit          toggle = 1'b0;

    imem_loader #(.ADDR_W(ADDR_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .cpu_reset (cpu_reset),
        .busy      (busy),
        .done      (done),
        .error     (error)
    );

    always #5 clk = ~clk;

    // Capture every memory write half a cycle after it is presented.
    always @(negedge clk) begin
        if (reset === 1'b0 && mem_we === 1'b1) wr_q.push_back({mem_addr, mem_wdata});
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Offers each byte until it is accepted; mode 0 = always valid, 1 = alternate, 2 = random gaps.
    task automatic applyStimulus(input bq_t bytes, input int mode);
        int  waitc;
        bit  took;
        foreach (bytes[k]) begin
            waitc = 0;
            forever begin
                case (mode)
                    0:       in_valid = 1'b1;
                    1:       in_valid = toggle;
                    default: in_valid = 1'($urandom_range(0, 1));
                endcase
                toggle  = ~toggle;
                in_data = in_valid ? bytes[k] : 8'($urandom);
                took    = in_valid && in_ready;
                step();
                if (took) break;
                waitc++;
                if (waitc > 40) begin
                    checks++;
                    failures++;
                    $error("[TB] FAIL stream_timeout observed=byte%0d_not_accepted expected=accepted", k);
                    in_valid = 1'b0;
                    return;
                end
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic runImage(input bq_t data, input int n, input int mode, input bit badsum);
        bq_t         s;
        bit          overflow;
        bit          exp_err;
        logic [7:0]  sum;
        logic [7:0]  cks;
        logic [31:0] w;
        int          nw;
        overflow = (n > CAP);
        exp_err  = overflow;
        s.push_back(8'(n));
        s.push_back(8'(n >> 8));
        if (!overflow) foreach (data[k]) s.push_back(data[k]);
`ifdef LOADER_CHECKSUM_EN
        if (!overflow) begin
            sum = 8'h00;
            foreach (s[k]) sum = sum + s[k];
            cks = 8'h00 - sum;
            if (badsum) cks = cks - 8'd1;
            s.push_back(cks);
            exp_err = badsum;
        end
`else
        sum = 8'h00;
        cks = 8'h00;
`endif
        wr_q.delete();
        start = 1'b1;
        step();
        start = 1'b0;
        checkOutput("ready_after_start", {31'd0, in_ready}, 32'd1);
        checkOutput("busy_after_start", {31'd0, busy}, 32'd1);
        checkOutput("cpu_reset_loading", {31'd0, cpu_reset}, 32'd1);
        applyStimulus(s, mode);
        if (overflow) begin
            step();
            checkOutput("ovf_error", {31'd0, error}, 32'd1);
            checkOutput("ovf_cpu_reset", {31'd0, cpu_reset}, 32'd1);
            checkOutput("ovf_in_ready", {31'd0, in_ready}, 32'd0);
            checkOutput("ovf_busy", {31'd0, busy}, 32'd0);
            in_valid = 1'b1;
            in_data  = 8'hA5;
            repeat (3) step();
            in_valid = 1'b0;
            checkOutput("ovf_error_held", {31'd0, error}, 32'd1);
            checkOutput("ovf_wr_count", 32'(wr_q.size()), 32'd0);
        end else begin
`ifdef LOADER_CHECKSUM_EN
            checkOutput("end_done", {31'd0, done}, {31'd0, !exp_err});
            checkOutput("end_error", {31'd0, error}, {31'd0, exp_err});
            checkOutput("end_cpu_reset", {31'd0, cpu_reset}, {31'd0, exp_err});
`else
            if (n > 0) begin
                checkOutput("flush_we", {31'd0, mem_we}, 32'd1);
                checkOutput("flush_addr", mem_addr, 32'(4 * (n - 1)));
                checkOutput("flush_done", {31'd0, done}, 32'd0);
            end
            step();
            checkOutput("end_done", {31'd0, done}, 32'd1);
            checkOutput("end_cpu_reset", {31'd0, cpu_reset}, 32'd0);
            checkOutput("end_error", {31'd0, error}, 32'd0);
`endif
            checkOutput("end_busy", {31'd0, busy}, 32'd0);
            repeat (2) step();
            checkOutput("wr_count", 32'(wr_q.size()), 32'(n));
            nw = (wr_q.size() < n) ? wr_q.size() : n;
            for (int i = 0; i < nw; i++) begin
                w = {data[4*i+3], data[4*i+2], data[4*i+1], data[4*i]};
                checkOutput($sformatf("wr%0d_addr", i), wr_q[i][63:32], 32'(4 * i));
                checkOutput($sformatf("wr%0d_data", i), wr_q[i][31:0], w);
            end
        end
    endtask

    initial begin
        bq_t img;
        bq_t rnd;
        bq_t part;
        int  n;

        $display("[TB] reset");
        repeat (3) step();
        checkOutput("rst_in_ready", {31'd0, in_ready}, 32'd0);
        checkOutput("rst_mem_we", {31'd0, mem_we}, 32'd0);
        checkOutput("rst_mem_addr", mem_addr, 32'd0);
        checkOutput("rst_mem_wdata", mem_wdata, 32'd0);
        checkOutput("rst_cpu_reset", {31'd0, cpu_reset}, 32'd1);
        checkOutput("rst_busy", {31'd0, busy}, 32'd0);
        checkOutput("rst_done", {31'd0, done}, 32'd0);
        checkOutput("rst_error", {31'd0, error}, 32'd0);
        reset = 1'b0;
        step();

        $display("[TB] two-word image, continuous and toggled valid");
        img = '{8'h13, 8'h05, 8'h00, 8'h00, 8'h93, 8'h05, 8'h10, 8'h00};
        runImage(img, 2, 0, 1'b0);
        checkOutput("known_word0", wr_q.size() > 0 ? wr_q[0][31:0] : 32'hx, 32'h00000513);
        checkOutput("known_word1", wr_q.size() > 1 ? wr_q[1][31:0] : 32'hx, 32'h00100593);
        runImage(img, 2, 1, 1'b0);

        $display("[TB] length overflow then recovery");
        rnd.delete();
        runImage(rnd, 5, 0, 1'b0);
        rnd = '{8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom)};
        runImage(rnd, 1, 0, 1'b0);

        $display("[TB] empty image");
        rnd.delete();
        runImage(rnd, 0, 0, 1'b0);

`ifdef LOADER_CHECKSUM_EN
        $display("[TB] checksum good and bad");
        part = '{8'h01, 8'h02, 8'h03, 8'h04};
        runImage(part, 1, 0, 1'b0);
        runImage(part, 1, 0, 1'b1);
`endif

        $display("[TB] reset in the middle of a load");
        wr_q.delete();
        start = 1'b1;
        step();
        start = 1'b0;
        part = '{8'h02, 8'h00, 8'h13, 8'h05, 8'h00, 8'h00, 8'h93, 8'h05};
        applyStimulus(part, 0);
        reset = 1'b1;
        step();
        checkOutput("mid_rst_busy", {31'd0, busy}, 32'd0);
        checkOutput("mid_rst_cpu_reset", {31'd0, cpu_reset}, 32'd1);
        checkOutput("mid_rst_in_ready", {31'd0, in_ready}, 32'd0);
        checkOutput("mid_rst_mem_we", {31'd0, mem_we}, 32'd0);
        checkOutput("mid_rst_wr_count", 32'(wr_q.size()), 32'd1);
        checkOutput("mid_rst_wr0", wr_q.size() > 0 ? wr_q[0][31:0] : 32'hx, 32'h00000513);
        reset = 1'b0;
        step();
        runImage(img, 2, 2, 1'b0);

        $display("[TB] randomized images");
        for (int it = 0; it < 12; it++) begin
            n = $urandom_range(0, CAP + 2);
            rnd.delete();
            if (n <= CAP) for (int b = 0; b < 4 * n; b++) rnd.push_back(8'($urandom));
            runImage(rnd, n, $urandom_range(0, 2), 1'($urandom_range(0, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
